// File: rtl/serial_add_sched.sv
// serial_add_sched: bit-serial add scheduler.
// One full-adder cell plus a carry flop is shared by two requesters under
// round-robin arbitration. The granted operands are shifted LSB-first through
// the cell, one bit per clock, and the WIDTH-bit Sum and final Cout are
// returned with a one-cycle Done pulse.
// Optional feature: define SERIAL_SUB_EN to add Sub0/Sub1 inputs that turn the
// operation into A-B (B inverted at capture, carry seeded with 1).
module serial_add_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Req0,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
`ifdef SERIAL_SUB_EN
    input  logic             Sub0,
    input  logic             Sub1,
`endif
    output logic             Grant0,
    output logic             Grant1,
    output logic             Busy,
    output logic             Done,
    output logic             DoneId,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Count value on the edge that consumes the operand MSB.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant0_q, grant0_d;
    logic             grant1_q, grant1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             pick;
    logic [WIDTH-1:0] b_sel;
    logic             sub_sel;
    logic             bit_s;
    logic             bit_c;

    // Next-state, datapath and output logic for the arbitration/shift sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        grant0_d  = 1'b0;
        grant1_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        pick      = 1'b0;
        b_sel     = '0;
        sub_sel   = 1'b0;
        bit_s     = 1'b0;
        bit_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    // A lone requester wins outright; on contention the pointer decides.
                    pick  = (Req0 && Req1) ? ptr_q : Req1;
                    b_sel = pick ? B1 : B0;
`ifdef SERIAL_SUB_EN
                    sub_sel = pick ? Sub1 : Sub0;
`endif
                    a_d      = pick ? A1 : A0;
                    b_d      = sub_sel ? ~b_sel : b_sel;
                    carry_d  = sub_sel;
                    cnt_d    = '0;
                    res_d    = '0;
                    id_d     = pick;
                    ptr_d    = ~pick;
                    grant0_d = ~pick;
                    grant1_d = pick;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                bit_s   = fa_sum(a_q[0], b_q[0], carry_q);
                bit_c   = fa_carry(a_q[0], b_q[0], carry_q);
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d     = {bit_s, res_q[WIDTH-1:1]};
                    cout_d    = bit_c;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    state_d   = DONE;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any operation at once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            id_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            grant0_q  <= grant0_d;
            grant1_q  <= grant1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign Grant0 = grant0_q;
    assign Grant1 = grant1_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
    assign DoneId = done_id_q;
    assign Sum    = sum_q;
    assign Cout   = cout_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Testbench for serial_add_sched: table vectors, arbitration and reset
// sequences, then randomized operations against a behavioural model.
module tb_serial_add_sched;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b1;
    logic             Req0 = 1'b0;
    logic             Req1 = 1'b0;
    logic [WIDTH-1:0] A0 = '0;
    logic [WIDTH-1:0] B0 = '0;
    logic [WIDTH-1:0] A1 = '0;
    logic [WIDTH-1:0] B1 = '0;
`ifdef SERIAL_SUB_EN
    logic             Sub0 = 1'b0;
    logic             Sub1 = 1'b0;
`endif
    logic             Grant0;
    logic             Grant1;
    logic             Busy;
    logic             Done;
    logic             DoneId;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    serial_add_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Req0    (Req0),
        .A0      (A0),
        .B0      (B0),
        .Req1    (Req1),
        .A1      (A1),
        .B1      (B1),
`ifdef SERIAL_SUB_EN
        .Sub0    (Sub0),
        .Sub1    (Sub1),
`endif
        .Grant0  (Grant0),
        .Grant1  (Grant1),
        .Busy    (Busy),
        .Done    (Done),
        .DoneId  (DoneId),
        .Sum     (Sum),
        .Cout    (Cout)
    );

    always #5 Clk = ~Clk;

    int vectors    = 0;
    int miscompares = 0;
    bit model_ptr  = 1'b0;   // round-robin pointer of the reference model

    typedef struct {
        bit               id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        bit               cout;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive Reset_n low mid-cycle, confirm outputs clear without a clock edge,
    // then release on the next falling edge.
    task automatic reset_dut();
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_outputs", 32'({Grant0, Grant1, Busy, Done, DoneId, Cout, Sum}), 32'h0);
        @(negedge Clk);
        Reset_n   = 1'b1;
        model_ptr = 1'b0;
    endtask

    // One complete transaction. The model decides who wins and what the result
    // must be; grant, latency, pulse widths and result are all checked here.
    task automatic do_op(input bit r0, input bit r1,
                         input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                         input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                         input bit s0, input bit s1,
                         output bit gid, output logic [WIDTH-1:0] gsum, output bit gcout);
        bit               pick;
        bit               es;
        logic [WIDTH-1:0] ea, eb, esum;
        bit               ecout;
        logic [WIDTH:0]   wide;
        bit               seen;
        int               k;

        pick = (r0 && r1) ? model_ptr : r1;
        ea   = pick ? a1 : a0;
        eb   = pick ? b1 : b0;
        es   = pick ? s1 : s0;
        if (es) begin
            esum  = ea - eb;
            ecout = (ea >= eb);
        end else begin
            wide  = {1'b0, ea} + {1'b0, eb};
            esum  = wide[WIDTH-1:0];
            ecout = wide[WIDTH];
        end

        A0 = a0; B0 = b0; A1 = a1; B1 = b1;
`ifdef SERIAL_SUB_EN
        Sub0 = s0; Sub1 = s1;
`endif
        Req0 = r0; Req1 = r1;

        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge Clk); #1;
            seen = Grant0 | Grant1;
        end
        gid = 1'b0; gsum = '0; gcout = 1'b0;
        if (!seen) begin
            check("grant_timeout", 32'(seen), 32'h1);
            Req0 = 1'b0; Req1 = 1'b0;
            return;
        end
        check("grant_id", 32'(Grant1), 32'(pick));
        check("grant_excl", 32'(Grant0 & Grant1), 32'h0);
        check("busy_at_grant", 32'(Busy), 32'h1);
        model_ptr = ~pick;

        // Withdraw requests and scramble operands: neither may affect the result.
        Req0 = 1'b0; Req1 = 1'b0;
        A0 = WIDTH'($urandom); B0 = WIDTH'($urandom);
        A1 = WIDTH'($urandom); B1 = WIDTH'($urandom);

        k = 0; seen = 1'b0;
        while (!seen && k < WIDTH + 4) begin
            @(posedge Clk); #1;
            k++;
            if (k == 1) check("grant_pulse_len", 32'(Grant0 | Grant1), 32'h0);
            seen = Done;
        end
        check("done_latency", 32'(k), 32'(WIDTH));
        check("done_grant_excl", 32'(Grant0 | Grant1), 32'h0);
        check("done_id", 32'(DoneId), 32'(pick));
        check("sum", 32'(Sum), 32'(esum));
        check("cout", 32'(Cout), 32'(ecout));
        gid = DoneId; gsum = Sum; gcout = Cout;

        @(posedge Clk); #1;
        check("done_pulse_len", 32'(Done), 32'h0);
        check("busy_release", 32'(Busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit               gid;
        logic [WIDTH-1:0] gsum;
        bit               gcout;
        bit               bad;
        int               gq[$];
        int               gedge[$];
        int               dq[$];
        int               dres[$];
        int               exp_id[3];
        int               exp_res[3];

        tbl[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0};
        tbl[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1};
        tbl[2] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0};
        tbl[3] = '{1'b1, 8'h01, 8'h02, 8'h03, 1'b0};
        tbl[4] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
        tbl[5] = '{1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7] = '{1'b1, 8'hAA, 8'h55, 8'hFF, 1'b0};

        // Power-on reset, asserted between clock edges.
        #2;
        Reset_n = 1'b0;
        #1;
        check("por_outputs", 32'({Grant0, Grant1, Busy, Done, DoneId, Cout, Sum}), 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        check("busy_after_reset", 32'(Busy), 32'h0);

        // Table vectors; each result must hold after Done until the next Done.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].id)
                do_op(1'b0, 1'b1, WIDTH'($urandom), WIDTH'($urandom), tbl[i].a, tbl[i].b,
                      1'b0, 1'b0, gid, gsum, gcout);
            else
                do_op(1'b1, 1'b0, tbl[i].a, tbl[i].b, WIDTH'($urandom), WIDTH'($urandom),
                      1'b0, 1'b0, gid, gsum, gcout);
            check("tbl_sum", 32'(gsum), 32'(tbl[i].sum));
            check("tbl_cout", 32'(gcout), 32'(tbl[i].cout));
            check("tbl_id", 32'(gid), 32'(tbl[i].id));
            repeat (3) @(posedge Clk);
            #1;
            check("tbl_sum_hold", 32'({Cout, Sum}), 32'({tbl[i].cout, tbl[i].sum}));
        end

        // Both requesters held from reset: grants alternate 0,1,0.
        reset_dut();
        A0 = 8'h35; B0 = 8'h4A; A1 = 8'hFF; B1 = 8'h01;
        Req0 = 1'b1; Req1 = 1'b1;
        bad = 1'b0;
        for (int cyc = 0; cyc < 4 * (WIDTH + 2) && dq.size() < 3; cyc++) begin
            @(posedge Clk); #1;
            if (Grant0 && Grant1) bad = 1'b1;
            if ((Grant0 || Grant1) && Done) bad = 1'b1;
            if (Grant0 || Grant1) begin
                gq.push_back(int'(Grant1));
                gedge.push_back(cyc);
                if (gq.size() == 3) begin
                    Req0 = 1'b0; Req1 = 1'b0;
                end
            end
            if (Done) begin
                dq.push_back(int'(DoneId));
                dres.push_back(int'({Cout, Sum}));
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
        @(posedge Clk); #1;
        model_ptr = 1'b1;
        exp_id  = '{0, 1, 0};
        exp_res = '{32'h07F, 32'h100, 32'h07F};
        check("arb_no_overlap", 32'(bad), 32'h0);
        check("arb_grant_count", 32'(gq.size()), 32'h3);
        check("arb_done_count", 32'(dq.size()), 32'h3);
        for (int i = 0; i < 3; i++) begin
            check("arb_grant_seq", (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF, 32'(exp_id[i]));
            check("arb_done_seq", (i < dq.size()) ? 32'(dq[i]) : 32'hFFFF, 32'(exp_id[i]));
            check("arb_result", (i < dres.size()) ? 32'(dres[i]) : 32'hFFFF, 32'(exp_res[i]));
        end
        check("arb_turnaround", (gedge.size() > 1) ? 32'(gedge[1] - gedge[0]) : 32'hFFFF,
              32'(WIDTH + 2));

        // Reset three shift cycles into an operation: no Done may follow.
        A0 = 8'h12; B0 = 8'h34; Req0 = 1'b1;
        bad = 1'b1;
        for (int i = 0; i < 4 && bad; i++) begin
            @(posedge Clk); #1;
            if (Grant0) bad = 1'b0;
        end
        check("midrst_grant", 32'(bad), 32'h0);
        Req0 = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({Grant0, Grant1, Busy, Done, DoneId, Cout, Sum}), 32'h0);
        @(negedge Clk);
        Reset_n   = 1'b1;
        model_ptr = 1'b0;
        bad = 1'b0;
        repeat (WIDTH + 4) begin
            @(posedge Clk); #1;
            if (Done || Busy) bad = 1'b1;
        end
        check("midrst_no_done", 32'(bad), 32'h0);
        do_op(1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 8'h02, 1'b0, 1'b0, gid, gsum, gcout);
        check("midrst_next_result", 32'({gid, gcout, gsum}), 32'({1'b1, 1'b0, 8'h03}));

`ifdef SERIAL_SUB_EN
        do_op(1'b1, 1'b0, 8'h10, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, gid, gsum, gcout);
        check("sub_no_borrow", 32'({gcout, gsum}), 32'({1'b1, 8'h0F}));
        do_op(1'b1, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0, gid, gsum, gcout);
        check("sub_borrow", 32'({gcout, gsum}), 32'({1'b0, 8'hFF}));
`endif

        // Randomized operations against the model, including contention.
        for (int n = 0; n < 40; n++) begin
            int  m;
            bit  rs0, rs1;
            m = int'($urandom_range(1, 3));
`ifdef SERIAL_SUB_EN
            rs0 = 1'($urandom); rs1 = 1'($urandom);
`else
            rs0 = 1'b0; rs1 = 1'b0;
`endif
            do_op(m[0], m[1], WIDTH'($urandom), WIDTH'($urandom),
                  WIDTH'($urandom), WIDTH'($urandom), rs0, rs1, gid, gsum, gcout);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Bit-serial add scheduler. One 1-bit adder cell (sum = A^B^C, carry = majority) plus a carry flip-flop is shared between two requesters.
- Round-robin arbitration picks a requester. The block latches that requester's WIDTH-bit operands and sequences them LSB-first through the cell, one bit per clock.
- It returns the WIDTH-bit Sum and Cout with a Done pulse.
- It sits beside the NAND-level adder cells in the lab datapath. It is the sequencer that lets one cell serve multiple clients.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset
- Req0  input  1  requester 0 request; held high until Grant0 seen
- A0  input  WIDTH  requester 0 operand A
- B0  input  WIDTH  requester 0 operand B
- Req1  input  1  requester 1 request
- A1  input  WIDTH  requester 1 operand A
- B1  input  WIDTH  requester 1 operand B
- Grant0  output  1  one-cycle pulse: requester 0 operands captured
- Grant1  output  1  one-cycle pulse: requester 1 operands captured
- Busy  output  1  high while an operation is in progress
- Done  output  1  one-cycle pulse: Sum/Cout valid
- DoneId  output  1  requester served by the current result (0/1)
- Sum  output  WIDTH  result; held until the next Done
- Cout  output  1  final carry; held until the next Done

Behaviour:
- Interface: one clock (Clk), reset asynchronous active-low (Reset_n). All outputs are registered.
- Reset (Reset_n=0, immediate):
  - state=IDLE, priority pointer=0.
  - Grant0=Grant1=Busy=Done=DoneId=0, Sum=0, Cout=0.
  - Carry FF, counter and operand shift registers cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - At an edge with Req0|Req1 high, grant one requester. If only one is requesting, grant it. If both, grant the one the pointer selects.
  - Capture that requester's A/B into shift registers. Carry=0, count=0.
  - Pulse the matching Grant for exactly the next cycle. Busy=1, next state SHIFT.
  - Pointer becomes the index of the non-granted requester.
- SHIFT, at each edge:
  - Compute s = a[0]^b[0]^c and c' = ab|ac|bc.
  - Shift s into result MSB (result shifts right); shift operands right; carry <= c'; count++.
  - On the edge processing bit WIDTH-1 (count==WIDTH-1), go to DONE. Load Sum from the final result vector, Cout=c', Done=1, DoneId=granted index.
- DONE: lasts one cycle. Next edge: Done=0, Busy=0, state IDLE.
- Latency: grant edge + WIDTH SHIFT edges. Done is high in cycle WIDTH+1 after the grant edge. The minimum request-to-request turnaround is WIDTH+2 cycles.
- Req inputs are ignored while Busy=1. Operand changes after the grant edge have no effect.
- Grant0 and Grant1 are never high together. Done and Grant are never high together.
- Arithmetic is modulo 2^WIDTH. The overflow carry appears only on Cout.
- Reset mid-operation:
  - Abort immediately; outputs return to their reset values and no Done is produced.
  - The in-flight request is lost; the requester must re-request.

Optional Feature:
- Macro SERIAL_SUB_EN.
- Defined:
  - Adds inputs Sub0 and Sub1 (1 bit each), sampled at the grant edge.
  - If the sampled Sub bit is 1, B is inverted at capture and the carry FF initialises to 1, so the operation is A-B.
  - Cout=1 means no borrow (A>=B unsigned).
- Undefined: Sub ports absent; add only, carry initialises to 0.

Test Plan:
- Reset: assert Reset_n=0 mid-cycle -> all outputs 0 asynchronously; Busy=0 after release.
- Req0=1, A0=0x35, B0=0x4A -> Grant0 pulse 1 cycle; Done at cycle 9 after grant edge; Sum=0x7F, Cout=0, DoneId=0.
- Req1=1, A1=0xFF, B1=0x01 -> Grant1 pulse; Done with Sum=0x00, Cout=1, DoneId=1. Sum holds 0x00 until next Done.
- Req0=Req1=1 held after reset:
  - Grant0 first (pointer=0), then Grant1 on the IDLE after its Done, then Grant0 again.
  - DoneId sequence 0,1,0; no double grants.
- Req0 with 0x12+0x34; drop Reset_n low 3 SHIFT cycles in -> no Done. After release, Req1 0x01+0x02 -> Sum=0x03, Cout=0.
- With SERIAL_SUB_EN: Req0, Sub0=1, A0=0x10, B0=0x01 -> Sum=0x0F, Cout=1. Then A0=0x01, B0=0x02 -> Sum=0xFF, Cout=0.
